// File: rtl/visualizer_pkg.sv
// visualizer_pkg: shared geometry, RGB332 palette, render states and tile colour rule
package visualizer_pkg;
  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int MAG_W = 5;
  localparam int COL_W = $clog2(COLS);
  localparam int ADDR_W = 10;
  localparam int NPIX = COLS * ROWS;
  localparam logic [7:0] C_GREEN = 8'b000_111_00;
  localparam logic [7:0] C_YELLOW = 8'b111_111_00;
  localparam logic [7:0] C_RED = 8'b111_000_00;
  localparam logic [7:0] C_PEAK = 8'hFF;
  localparam logic [7:0] C_BG = 8'h00;
  typedef enum logic {S_IDLE, S_RENDER} state_t;
  typedef logic [MAG_W-1:0] mag_t;
  // h counts up from the bottom row; the marker sits one tile below the peak height
  function automatic logic [7:0] tile_color(mag_t h, mag_t m, mag_t p);
    return (h < m) ? ((h < MAG_W'(8)) ? C_GREEN : (h < MAG_W'(16)) ? C_YELLOW : C_RED)
         : (p > m && h + MAG_W'(1) == p) ? C_PEAK : C_BG;
  endfunction
endpackage

// File: rtl/bar_peak_tracker.sv
// bar_peak_tracker: per-column peak hold with one-step decay every DECAY_FRAMES snapshots
module bar_peak_tracker
  import visualizer_pkg::*;
#(
  parameter int DECAY_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_snap,
  input  logic [COLS-1:0][MAG_W-1:0]  i_active,
  output logic [COLS-1:0][MAG_W-1:0]  o_peak,
  output logic [COLS-1:0][MAG_W-1:0]  o_peak_nxt
);
  localparam int DW = DECAY_FRAMES > 1 ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_FRAMES - 1);
  logic [COLS-1:0][MAG_W-1:0] r_peak;
  logic [DW-1:0] r_dcnt;
  logic w_decay;
  assign w_decay = r_dcnt == D_LAST;
  assign o_peak = r_peak;
  // a peak above the new magnitude is strictly positive, so the decrement never wraps
  always_comb begin
    o_peak_nxt = r_peak;
    for (int c = 0; c < COLS; c++)
      o_peak_nxt[c] = i_active[c] >= r_peak[c] ? i_active[c]
                    : w_decay ? r_peak[c] - MAG_W'(1) : r_peak[c];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= '0;
      r_dcnt <= '0;
    end else if (i_snap) begin
      r_peak <= o_peak_nxt;
      r_dcnt <= w_decay ? '0 : r_dcnt + DW'(1);
    end
  end
endmodule

// File: rtl/bar_renderer.sv
// bar_renderer: renders band magnitudes with peak markers into a COLS x ROWS RGB332 tile frame
module bar_renderer
  import visualizer_pkg::*;
#(
  parameter int DECAY_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              band_valid,
  output logic              band_ready,
  input  logic [COL_W-1:0]  band_idx,
  input  logic [MAG_W-1:0]  band_mag,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [7:0]        write_color,
  output logic              write_en,
  output logic              busy,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NPIX - 1);
  state_t r_state, w_state_nxt;
  logic [COLS-1:0][MAG_W-1:0] r_shadow, r_active, w_peak, w_peak_nxt;
  logic w_snap, w_accept;
  logic [ADDR_W-1:0] w_na;
  logic [COL_W-1:0] w_col;
  mag_t w_h, w_m, w_p;
  assign busy = r_state == S_RENDER;
  assign band_ready = ~busy;
  assign w_accept = band_valid & band_ready;
  assign w_snap = frame_start & ~busy;
  bar_peak_tracker #(.DECAY_FRAMES(DECAY_FRAMES)) u_peak (
    .clk(clk), .reset(reset), .i_snap(w_snap), .i_active(r_shadow),
    .o_peak(w_peak), .o_peak_nxt(w_peak_nxt)
  );
  // tile 0 is coloured on the snapshot edge itself, so it reads the values being loaded
  always_comb begin
    w_state_nxt = w_snap ? S_RENDER : (busy && RAM_addr == A_LAST) ? S_IDLE : r_state;
    w_na = w_snap ? '0 : RAM_addr + ADDR_W'(1);
    w_col = COL_W'(w_na % ADDR_W'(COLS));
    w_h = MAG_W'(ROWS - 1 - int'(w_na / ADDR_W'(COLS)));
    w_m = w_snap ? r_shadow[w_col] : r_active[w_col];
    w_p = w_snap ? w_peak_nxt[w_col] : w_peak[w_col];
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  // band_idx is exactly COL_W wide, so every offered index addresses a real column
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      RAM_addr <= '0;
      write_color <= C_BG;
      write_en <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_accept) r_shadow[band_idx] <= band_mag > MAG_W'(ROWS) ? MAG_W'(ROWS) : band_mag;
      if (w_snap) r_active <= r_shadow;
      if (frame_start && busy) overrun <= 1'b1;
      write_en <= w_state_nxt == S_RENDER;
      if (w_state_nxt == S_RENDER) begin
        RAM_addr <= w_na;
        write_color <= tile_color(w_h, w_m, w_p);
      end
    end
  end
endmodule

// File: tb/tb_bar_renderer.sv
// tb_bar_renderer: table vectors, hand corner sequences and random frames against a frame-level model
module tb_bar_renderer;
  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, band_valid = 1'b0;
  logic [4:0] band_idx = '0, band_mag = '0;
  logic band_ready, write_en, busy, overrun;
  logic [9:0] RAM_addr;
  logic [7:0] write_color;
  int n_chk = 0, n_pass = 0;
  int m_shadow[32], m_active[32], m_peak[32], m_dcnt;
  logic [7:0] exp_img[768], got_img[768];
  typedef struct {int idx; int mag; int addr; logic [7:0] color;} vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  bar_renderer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .band_valid(band_valid),
    .band_ready(band_ready), .band_idx(band_idx), .band_mag(band_mag), .RAM_addr(RAM_addr),
    .write_color(write_color), .write_en(write_en), .busy(busy), .overrun(overrun)
  );

  function automatic logic [7:0] ref_color(int h, int m, int p);
    if (h < m) return h < 8 ? 8'h1C : h < 16 ? 8'hFC : 8'hE0;
    if (p > m && h == p - 1) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 32; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
      m_peak[c] = 0;
    end
    m_dcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send_band(int idx, int mag);
    band_valid = 1'b1;
    band_idx = 5'(idx);
    band_mag = 5'(mag);
    step();
    band_valid = 1'b0;
    m_shadow[idx] = mag > 24 ? 24 : mag;
  endtask

  task automatic model_snap();
    for (int c = 0; c < 32; c++) begin
      m_active[c] = m_shadow[c];
      if (m_active[c] >= m_peak[c]) m_peak[c] = m_active[c];
      else if (m_dcnt == 3) m_peak[c] = m_peak[c] - 1;
    end
    m_dcnt = (m_dcnt + 1) % 4;
    for (int a = 0; a < 768; a++)
      exp_img[a] = ref_color(23 - a / 32, m_active[a % 32], m_peak[a % 32]);
  endtask

  task automatic run_frame(int inject_at, int reset_at, int side_idx, int side_mag);
    frame_start = 1'b1;
    if (side_idx >= 0) begin
      band_valid = 1'b1;
      band_idx = 5'(side_idx);
      band_mag = 5'(side_mag);
    end
    step();
    frame_start = 1'b0;
    band_valid = 1'b0;
    model_snap();
    if (side_idx >= 0) m_shadow[side_idx] = side_mag > 24 ? 24 : side_mag;
    for (int a = 0; a < 768; a++) begin
      chk($sformatf("write@%0d {we,busy,ready,addr,color}", a),
          {write_en, busy, band_ready, RAM_addr, write_color},
          {1'b1, 1'b1, 1'b0, 10'(a), exp_img[a]});
      got_img[a] = write_color;
      if (a == inject_at) frame_start = 1'b1;
      if (a == reset_at) reset = 1'b1;
      step();
      frame_start = 1'b0;
      if (a == reset_at) begin
        reset = 1'b0;
        chk("midreset {we,busy,ready,ovr,addr,color}",
            {write_en, busy, band_ready, overrun, RAM_addr, write_color}, {4'b0010, 10'd0, 8'h00});
        model_reset();
        return;
      end
    end
    chk("frame_end {we,busy,ready,addr}", {write_en, busy, band_ready, RAM_addr},
        {3'b001, 10'd767});
  endtask

  initial begin
    tbl[0] = '{0, 10, 736, 8'h1C};
    tbl[1] = '{0, 10, 448, 8'hFC};
    tbl[2] = '{0, 10, 416, 8'h00};
    tbl[3] = '{5, 31, 5, 8'hE0};
    tbl[4] = '{5, 31, 741, 8'h1C};
    tbl[5] = '{7, 16, 263, 8'hFC};
    tbl[6] = '{7, 16, 231, 8'h00};
    tbl[7] = '{9, 8, 521, 8'h1C};
    tbl[8] = '{9, 8, 489, 8'h00};
    tbl[9] = '{2, 0, 738, 8'h00};
    tbl[10] = '{31, 24, 31, 8'hE0};
    tbl[11] = '{31, 17, 255, 8'hE0};
    step();
    step();
    reset = 1'b0;
    model_reset();
    chk("reset {we,busy,ready,ovr,addr,color}",
        {write_en, busy, band_ready, overrun, RAM_addr, write_color}, {4'b0010, 10'd0, 8'h00});
    run_frame(-1, -1, -1, 0);
    chk("overrun_idle", overrun, 0);
    for (int i = 0; i < 12; i++) begin
      do_reset();
      send_band(tbl[i].idx, tbl[i].mag);
      run_frame(-1, -1, -1, 0);
      chk($sformatf("tbl%0d addr %0d", i, tbl[i].addr), got_img[tbl[i].addr], tbl[i].color);
    end
    do_reset();
    send_band(3, 20);
    run_frame(-1, -1, -1, 0);
    send_band(3, 0);
    run_frame(-1, -1, -1, 0);
    chk("peak_marker addr 131", got_img[131], 8'hFF);
    run_frame(-1, -1, -1, 0);
    run_frame(-1, -1, -1, 0);
    chk("peak_decayed addr 163", got_img[163], 8'hFF);
    for (int f = 0; f < 6; f++) run_frame(-1, -1, -1, 0);
    do_reset();
    send_band(1, 12);
    run_frame(98, -1, -1, 0);
    chk("overrun_set", overrun, 1);
    run_frame(-1, -1, -1, 0);
    chk("overrun_sticky", overrun, 1);
    do_reset();
    send_band(4, 15);
    send_band(20, 24);
    run_frame(-1, 298, -1, 0);
    send_band(6, 9);
    run_frame(-1, -1, -1, 0);
    do_reset();
    send_band(10, 5);
    run_frame(-1, -1, 10, 22);
    chk("same_cycle_band old", got_img[23 * 32 + 10 - 5 * 32], 8'h00);
    run_frame(-1, -1, -1, 0);
    chk("same_cycle_band new", got_img[2 * 32 + 10], 8'hE0);
    do_reset();
    for (int f = 0; f < 8; f++) begin
      int n = int'($urandom_range(0, 12));
      for (int k = 0; k < n; k++) send_band(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      run_frame(-1, -1, -1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
